// File: rtl/imem_loader.sv
// imem_loader: frames a UART byte stream into instruction RAM word writes, holding the CPU in reset while loading
module imem_loader #(
    parameter int ADDR_WIDTH = 9,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [31:0]           imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err,
    output logic [ADDR_WIDTH:0]   words_loaded
);
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE} state_t;
    localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_WIDTH);

    state_t state_q, state_d;
    logic [15:0] len_q, len_d, len_full;
    logic [31:0] asm_q, asm_d, idle_q, idle_d, addr_q, addr_d, wdata_q, wdata_d, word;
    logic [1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH:0] idx_q, idx_d, words_q, words_d;
    logic we_q, we_d, hold_q, hold_d, done_q, done_d, err_q, err_d;
    logic accept, in_frame;

    assign in_ready = state_q inside {IDLE, LEN_HI, LEN_LO, DATA};
    assign in_frame = state_q inside {LEN_HI, LEN_LO, DATA};
    assign accept = in_valid && in_ready;
    assign len_full = {len_q[15:8], in_data};
    assign word = {asm_q[23:0], in_data};

    always_comb begin
        state_d = state_q;
        len_d = len_q;
        asm_d = asm_q;
        idle_d = '0;
        addr_d = addr_q;
        wdata_d = wdata_q;
        cnt_d = cnt_q;
        idx_d = idx_q;
        words_d = words_q;
        we_d = 1'b0;
        done_d = 1'b0;
        err_d = 1'b0;
        case (state_q)
            IDLE: if (accept && in_data == SYNC_BYTE) begin
                state_d = LEN_HI;
                idx_d = '0;
                words_d = '0;
                cnt_d = '0;
            end
            LEN_HI: if (accept) begin
                len_d = {in_data, 8'h00};
                state_d = LEN_LO;
            end
            LEN_LO: if (accept) begin
                len_d = len_full;
                if (len_full == 16'd0) begin
                    state_d = DONE;
                    done_d = 1'b1;
                end else if ({1'b0, len_full} > CAPACITY) begin
                    state_d = IDLE;
                    err_d = 1'b1;
                end else begin
                    state_d = DATA;
                end
            end
            DATA: if (accept) begin
                asm_d = word;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = WRITE;
                    we_d = 1'b1;
                    addr_d = 32'({idx_q[ADDR_WIDTH-1:0], 2'b00});
                    wdata_d = word;
                end
            end
            WRITE: begin
                idx_d = idx_q + (ADDR_WIDTH+1)'(1);
                words_d = words_q + (ADDR_WIDTH+1)'(1);
                if (16'(idx_q) == len_q - 16'd1) begin
                    state_d = DONE;
                    done_d = 1'b1;
                end else begin
                    state_d = DATA;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (in_frame && !accept) begin
            idle_d = idle_q + 32'd1;
            if (idle_q == IDLE_LAST) begin
                state_d = IDLE;
                err_d = 1'b1;
                idle_d = '0;
            end
        end
        hold_d = (state_d != IDLE) || err_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            len_q <= '0;
            asm_q <= '0;
            idle_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            cnt_q <= '0;
            idx_q <= '0;
            words_q <= '0;
            we_q <= 1'b0;
            hold_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q <= len_d;
            asm_q <= asm_d;
            idle_q <= idle_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            words_q <= words_d;
            we_q <= we_d;
            hold_q <= hold_d;
            done_q <= done_d;
            err_q <= err_d;
        end
    end

    assign imem_we = we_q;
    assign imem_addr = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold = hold_q;
    assign load_done = done_q;
    assign load_err = err_q;
    assign words_loaded = words_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frame stimulus checked against a byte-stream parsing model of the loader
module tb_imem_loader;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [7:0] in_data = '0;
    logic in_valid = 1'b0;
    logic in_ready, imem_we, cpu_hold, load_done, load_err;
    logic [31:0] imem_addr, imem_wdata;
    logic [9:0] words_loaded;

    int checks = 0, errors = 0, cyc = 0, last_acc = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, hold_cnt = 0;
    int rdy_low = 0, we_low = 0, done_low = 0;
    int done_cyc = 0, err_cyc = 0, rise_cyc = 0, fall_cyc = 0;
    logic prev_hold = 1'b0;
    logic [63:0] got_w[$];
    logic [63:0] exp_w[$];
    int acc_q[$];
    bit exp_done, exp_err;
    int exp_words;

    imem_loader #(.ADDR_WIDTH(9), .TIMEOUT_CYCLES(100), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
        .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation only; every comparison lives in the test tasks.
    always @(negedge clk) begin
        if (imem_we) got_w.push_back({imem_addr, imem_wdata});
        if (load_done) begin done_cnt++; done_cyc = cyc; end
        if (load_err) begin err_cnt++; err_cyc = cyc; end
        if (load_done && load_err) both_cnt++;
        if (cpu_hold) hold_cnt++;
        if (cpu_hold && !prev_hold) rise_cyc = cyc;
        if (!cpu_hold && prev_hold) fall_cyc = cyc;
        prev_hold = cpu_hold;
        if (!in_ready) begin
            rdy_low++;
            if (imem_we) we_low++;
            if (load_done) done_low++;
        end
    end

    task automatic model(input logic [7:0] s[$]);
        int i = 0;
        int n;
        exp_w.delete();
        exp_done = 0;
        exp_err = 0;
        exp_words = 0;
        while (i < s.size() && s[i] != 8'hA5) i++;
        i++;
        if (i + 1 >= s.size()) begin exp_err = 1; return; end
        n = int'({s[i], s[i+1]});
        i += 2;
        if (n > 512) begin exp_err = 1; return; end
        for (int w = 0; w < n; w++) begin
            if (i + 3 >= s.size()) begin exp_err = 1; return; end
            exp_w.push_back({32'(w * 4), s[i], s[i+1], s[i+2], s[i+3]});
            exp_words++;
            i += 4;
        end
        exp_done = 1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_data = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (!in_ready) begin errors++; $display("FAIL byte_accept: in_ready stayed %b for %0d cycles, required 1", in_ready, n); end
        @(posedge clk); #1;
        last_acc = cyc;
        acc_q.push_back(cyc);
    endtask

    task automatic send_frame(input logic [7:0] s[$], input int gap_max);
        foreach (s[i]) send_byte(s[i], gap_max == 0 ? 0 : int'($urandom_range(0, gap_max)));
        in_valid = 1'b0;
    endtask

    task automatic wait_end(input int d0, input int e0);
        int n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 300) begin @(posedge clk); #1; n++; end
        checks++;
        if (n >= 300) begin errors++; $display("FAIL frame_end: no done/err after %0d cycles, required a pulse", n); end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        logic [78:0] got;
        reset = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        got = {in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err, words_loaded};
        checks++;
        if (got !== {1'b1, 78'd0}) begin errors++; $display("FAIL reset_values: got %h, required %h", got, {1'b1, 78'd0}); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_nominal();
        logic [7:0] s[$] = '{8'hA5, 8'h00, 8'h03, 8'h08, 8'h10, 8'h00, 8'h03, 8'h20, 8'h15, 8'h00, 8'h01, 8'h00, 8'h15, 8'hAF, 8'h80};
        int w0 = got_w.size(), d0 = done_cnt, e0 = err_cnt;
        model(s);
        send_frame(s, 0);
        wait_end(d0, e0);
        checks++;
        if (got_w.size() - w0 != exp_w.size()) begin errors++; $display("FAIL nominal_writes: got %0d writes, required %0d", got_w.size() - w0, exp_w.size()); end
        else foreach (exp_w[k]) begin
            checks++;
            if (got_w[w0+k] !== exp_w[k]) begin errors++; $display("FAIL nominal_write%0d: got %h, required %h", k, got_w[w0+k], exp_w[k]); end
        end
        checks++;
        if (exp_w.size() != 3 || exp_w[2] !== 64'h00000008_0015AF80) begin errors++; $display("FAIL nominal_model: model gave %0d writes, required 3 ending 0x8/0x0015AF80", exp_w.size()); end
        checks++;
        if (done_cnt - d0 != 1 || err_cnt != e0) begin errors++; $display("FAIL nominal_pulses: done %0d err %0d, required 1 and 0", done_cnt - d0, err_cnt - e0); end
        checks++;
        if (words_loaded !== 10'd3) begin errors++; $display("FAIL nominal_words: got %0d, required 3", words_loaded); end
        checks++;
        if (fall_cyc != done_cyc + 1) begin errors++; $display("FAIL nominal_hold_drop: hold fell at %0d, required %0d", fall_cyc, done_cyc + 1); end
    endtask

    task automatic test_garbage_n0();
        logic [7:0] s[$] = '{8'h12, 8'h34, 8'hA5, 8'h00, 8'h00};
        int w0 = got_w.size(), d0 = done_cnt, e0 = err_cnt, h0 = hold_cnt, a0 = acc_q.size();
        send_frame(s, 0);
        wait_end(d0, e0);
        checks++;
        if (got_w.size() != w0) begin errors++; $display("FAIL n0_writes: got %0d writes, required 0", got_w.size() - w0); end
        checks++;
        if (done_cnt - d0 != 1 || err_cnt != e0) begin errors++; $display("FAIL n0_pulses: done %0d err %0d, required 1 and 0", done_cnt - d0, err_cnt - e0); end
        checks++;
        if (rise_cyc != acc_q[a0+2]) begin errors++; $display("FAIL n0_hold_rise: rose at %0d, required %0d", rise_cyc, acc_q[a0+2]); end
        checks++;
        if (hold_cnt - h0 != acc_q[a0+4] - acc_q[a0+2] + 1) begin errors++; $display("FAIL n0_hold_len: %0d cycles, required %0d", hold_cnt - h0, acc_q[a0+4] - acc_q[a0+2] + 1); end
        checks++;
        if (done_cyc != acc_q[a0+4] || fall_cyc != done_cyc + 1) begin errors++; $display("FAIL n0_done_timing: done %0d fall %0d, required %0d and %0d", done_cyc, fall_cyc, acc_q[a0+4], acc_q[a0+4] + 1); end
    endtask

    task automatic test_overflow();
        logic [7:0] s[$] = '{8'hA5, 8'h02, 8'h01};
        logic [7:0] t[$];
        int w0 = got_w.size(), d0 = done_cnt, e0 = err_cnt;
        send_frame(s, 0);
        wait_end(d0, e0);
        checks++;
        if (err_cnt - e0 != 1 || done_cnt != d0 || got_w.size() != w0) begin errors++; $display("FAIL ovf_result: err %0d done %0d writes %0d, required 1 0 0", err_cnt - e0, done_cnt - d0, got_w.size() - w0); end
        checks++;
        if (err_cyc != last_acc || fall_cyc != err_cyc + 1) begin errors++; $display("FAIL ovf_timing: err %0d fall %0d, required %0d and %0d", err_cyc, fall_cyc, last_acc, last_acc + 1); end
        t = '{8'hA5, 8'h00, 8'h01, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        model(t);
        w0 = got_w.size(); d0 = done_cnt; e0 = err_cnt;
        send_frame(t, 0);
        wait_end(d0, e0);
        checks++;
        if (got_w.size() - w0 != 1 || got_w[w0] !== exp_w[0]) begin errors++; $display("FAIL ovf_reload: got %0d writes first %h, required 1 of %h", got_w.size() - w0, got_w.size() > w0 ? got_w[w0] : 64'd0, exp_w[0]); end
    endtask

    task automatic test_timeout();
        logic [7:0] s[$] = '{8'hA5, 8'h00, 8'h02, 8'h08, 8'h10, 8'h00, 8'h03, 8'h08, 8'h10};
        int w0 = got_w.size(), d0 = done_cnt, e0 = err_cnt, t0;
        model(s);
        send_frame(s, 0);
        t0 = last_acc;
        wait_end(d0, e0);
        checks++;
        if (got_w.size() - w0 != 1 || got_w[w0] !== 64'h00000000_08100003) begin errors++; $display("FAIL timeout_writes: got %0d writes, required 1 of 0x0/0x08100003", got_w.size() - w0); end
        checks++;
        if (err_cnt - e0 != 1 || done_cnt != d0 || exp_err != 1) begin errors++; $display("FAIL timeout_pulses: err %0d done %0d, required 1 and 0", err_cnt - e0, done_cnt - d0); end
        checks++;
        if (err_cyc - t0 < 99 || err_cyc - t0 > 101) begin errors++; $display("FAIL timeout_delay: %0d idle cycles, required about 100", err_cyc - t0); end
        checks++;
        if (words_loaded !== 10'(exp_words) || cpu_hold !== 1'b0) begin errors++; $display("FAIL timeout_state: words %0d hold %b, required %0d and 0", words_loaded, cpu_hold, exp_words); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s[$] = '{8'hA5, 8'h00, 8'h04};
        int w0 = got_w.size(), d0 = done_cnt, e0 = err_cnt, r0 = rdy_low, wl0 = we_low, dl0 = done_low;
        for (int i = 0; i < 16; i++) s.push_back(i == 5 ? 8'hA5 : 8'($urandom));
        model(s);
        send_frame(s, 0);
        wait_end(d0, e0);
        checks++;
        if (got_w.size() - w0 != exp_w.size()) begin errors++; $display("FAIL b2b_writes: got %0d writes, required %0d", got_w.size() - w0, exp_w.size()); end
        else foreach (exp_w[k]) begin
            checks++;
            if (got_w[w0+k] !== exp_w[k]) begin errors++; $display("FAIL b2b_write%0d: got %h, required %h", k, got_w[w0+k], exp_w[k]); end
        end
        checks++;
        if (rdy_low - r0 != 5 || we_low - wl0 != 4 || done_low - dl0 != 1) begin errors++; $display("FAIL b2b_ready: low %0d (write %0d done %0d), required 5 (4 1)", rdy_low - r0, we_low - wl0, done_low - dl0); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] s[$] = '{8'hA5, 8'h00, 8'h03};
        logic [7:0] t[$];
        logic [78:0] got;
        int w0 = got_w.size(), d0 = done_cnt, e0 = err_cnt;
        for (int i = 0; i < 12; i++) s.push_back(8'($urandom));
        for (int i = 0; i < 9; i++) send_byte(s[i], 0);
        in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        got = {in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err, words_loaded};
        checks++;
        if (got !== {1'b1, 78'd0}) begin errors++; $display("FAIL midreset_values: got %h, required %h", got, {1'b1, 78'd0}); end
        reset = 1'b1;
        repeat (150) begin @(posedge clk); #1; end
        checks++;
        if (err_cnt != e0 || done_cnt != d0 || got_w.size() - w0 != 1) begin errors++; $display("FAIL midreset_abort: err %0d done %0d writes %0d, required 0 0 1", err_cnt - e0, done_cnt - d0, got_w.size() - w0); end
        t = '{8'hA5, 8'h00, 8'h01, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        model(t);
        w0 = got_w.size(); d0 = done_cnt; e0 = err_cnt;
        send_frame(t, 0);
        wait_end(d0, e0);
        checks++;
        if (got_w.size() - w0 != 1 || got_w[w0] !== exp_w[0]) begin errors++; $display("FAIL midreset_restart: got %0d writes first %h, required 1 of %h", got_w.size() - w0, got_w.size() > w0 ? got_w[w0] : 64'd0, exp_w[0]); end
    endtask

    task automatic test_capacity();
        logic [7:0] s[$] = '{8'hA5, 8'h02, 8'h00};
        int w0 = got_w.size(), d0 = done_cnt, e0 = err_cnt;
        for (int i = 0; i < 2048; i++) s.push_back(8'($urandom));
        model(s);
        send_frame(s, 0);
        wait_end(d0, e0);
        checks++;
        if (got_w.size() - w0 != 512) begin errors++; $display("FAIL cap_writes: got %0d writes, required 512", got_w.size() - w0); end
        else foreach (exp_w[k]) begin
            checks++;
            if (got_w[w0+k] !== exp_w[k]) begin errors++; $display("FAIL cap_write%0d: got %h, required %h", k, got_w[w0+k], exp_w[k]); end
        end
        checks++;
        if (got_w.size() > w0 + 511 && got_w[w0+511][63:32] !== 32'h7FC) begin errors++; $display("FAIL cap_last_addr: got %h, required 000007fc", got_w[w0+511][63:32]); end
        checks++;
        if (words_loaded !== 10'd512 || done_cnt - d0 != 1) begin errors++; $display("FAIL cap_done: words %0d done %0d, required 512 and 1", words_loaded, done_cnt - d0); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            logic [7:0] s[$];
            int n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(513, 700)) : int'($urandom_range(0, 6));
            int w0 = got_w.size(), d0 = done_cnt, e0 = err_cnt;
            logic [7:0] g;
            repeat ($urandom_range(0, 3)) begin
                g = 8'($urandom);
                s.push_back(g == 8'hA5 ? 8'h00 : g);
            end
            s.push_back(8'hA5);
            s.push_back(8'(n >> 8));
            s.push_back(8'(n));
            if (n <= 512) for (int i = 0; i < 4 * n; i++) s.push_back($urandom_range(0, 7) == 0 ? 8'hA5 : 8'($urandom));
            model(s);
            send_frame(s, 3);
            wait_end(d0, e0);
            checks++;
            if (got_w.size() - w0 != exp_w.size()) begin errors++; $display("FAIL rand%0d_writes: got %0d writes, required %0d", it, got_w.size() - w0, exp_w.size()); end
            else foreach (exp_w[k]) begin
                checks++;
                if (got_w[w0+k] !== exp_w[k]) begin errors++; $display("FAIL rand%0d_write%0d: got %h, required %h", it, k, got_w[w0+k], exp_w[k]); end
            end
            checks++;
            if (done_cnt - d0 != int'(exp_done) || err_cnt - e0 != int'(exp_err)) begin errors++; $display("FAIL rand%0d_pulses: done %0d err %0d, required %0d %0d", it, done_cnt - d0, err_cnt - e0, exp_done, exp_err); end
            checks++;
            if (exp_done && words_loaded !== 10'(exp_words)) begin errors++; $display("FAIL rand%0d_words: got %0d, required %0d", it, words_loaded, exp_words); end
        end
        checks++;
        if (both_cnt != 0) begin errors++; $display("FAIL done_err_overlap: %0d cycles with both, required 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_garbage_n0();
        test_overflow();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_capacity();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
